servo_cmd_scheduler: RTL and testbench
======================================

SERVO_CMD_SCHEDULER -- requirements
Module: servo_cmd_scheduler

Interface
REQ-001 Parameter: STEP_TICKS, 250000, clock cycles per position step tick (10 ms at 25 MHz).
REQ-002 Parameter: POS_MIN, 16, lower saturation bound for pan and tilt.
REQ-003 Parameter: POS_MAX, 240, upper saturation bound for pan and tilt.
REQ-004 Parameter: POS_CENTER, 128, reset and homing target for pan and tilt.
REQ-005 Parameter: FIRE_TICKS, 12500000, cycles o_Fire is held high per shot.
REQ-006 Parameter: COOLDOWN_TICKS, 25000000, cycles of lockout after a shot.
REQ-007 Parameter: WDOG_TICKS, 250000000, idle cycles before homing starts (only used with WATCHDOG_EN).
REQ-008 Port: i_Clk  input  1  system clock; the only clock.
REQ-009 Port: i_Rst_L  input  1  reset, synchronous, active-low.
REQ-010 Port: i_Left / i_Right / i_Up / i_Down  input  1 each  direction command levels, synchronous to i_Clk.
REQ-011 Port: i_Trigger  input  1  fire request level, synchronous to i_Clk.
REQ-012 Port: o_Pan / o_Tilt  output  8 each  commanded servo positions.
REQ-013 Port: o_Fire  output  1  trigger servo drive, high while in FIRE.
REQ-014 Port: o_Busy  output  1  high while trigger FSM is not IDLE.
REQ-015 Port: o_Fire_Count  output  8  shots fired, wrapping.
REQ-016 Port: o_Homing  output  1  high while watchdog homing is active.

Function
REQ-017 Step counter SHALL count 0..STEP_TICKS-1 and wrap, asserting an internal one-cycle tick on the wrap cycle.
REQ-018 On tick: i_Left=1,i_Right=0 SHALL decrement o_Pan by 1; i_Right=1,i_Left=0 SHALL increment; both or neither SHALL hold.
REQ-019 On tick: i_Up=1,i_Down=0 SHALL increment o_Tilt by 1; i_Down=1,i_Up=0 SHALL decrement; both or neither SHALL hold.
REQ-020 Pan/tilt SHALL saturate: never below POS_MIN nor above POS_MAX; a step at a bound is a no-op.
REQ-021 Trigger FSM states SHALL be IDLE, FIRE, COOLDOWN.
REQ-022 IDLE->FIRE SHALL occur on the cycle after a rising edge of i_Trigger (registered previous value 0, current 1); o_Fire SHALL go high that same next cycle.
REQ-023 FIRE SHALL last exactly FIRE_TICKS cycles, then COOLDOWN for exactly COOLDOWN_TICKS cycles, then IDLE.
REQ-024 Rising edges during FIRE or COOLDOWN SHALL be ignored; i_Trigger held high across COOLDOWN SHALL NOT refire; a new rising edge is required.
REQ-025 o_Fire_Count SHALL increment by 1 on each IDLE->FIRE transition, wrapping 255->0.
REQ-026 o_Busy SHALL equal (state != IDLE), registered.
REQ-027 Position stepping and trigger FSM SHALL operate independently and concurrently.

Reset
REQ-028 With i_Rst_L=0 at a rising i_Clk edge: o_Pan=o_Tilt=POS_CENTER, FSM=IDLE, o_Fire=0, o_Busy=0, o_Fire_Count=0, o_Homing=0, all timers and the trigger edge register=0.
REQ-029 Reset asserted mid-FIRE or mid-COOLDOWN SHALL abort; o_Fire low on the cycle after the reset edge; no count increment.
REQ-030 After release, step counter SHALL restart from 0; first tick STEP_TICKS cycles later.

Configuration
REQ-031 Macro SERVO_WATCHDOG_EN defined: idle counter SHALL clear on any cycle with any direction input or i_Trigger high, else increment, saturating at WDOG_TICKS.
REQ-032 With SERVO_WATCHDOG_EN, at saturation o_Homing=1 and each tick SHALL move pan and tilt one step toward POS_CENTER (no move when equal); any input activity clears o_Homing and the counter on the next cycle.
REQ-033 Without SERVO_WATCHDOG_EN: no idle counter, o_Homing tied 0, positions hold when idle.

Verification (STEP_TICKS=4, FIRE_TICKS=3, COOLDOWN_TICKS=5, WDOG_TICKS=20, other defaults)
REQ-034 Reset, then i_Right=1 for 40 cycles -> o_Pan 128->138, one step per 4 cycles; o_Tilt stays 128.
REQ-035 i_Down=1 for 600 cycles -> o_Tilt falls to 16 and holds; i_Left=i_Right=1 -> o_Pan unchanged.
REQ-036 i_Trigger 0->1, held 20 cycles -> o_Fire high exactly 3 cycles, o_Busy high 8 cycles, o_Fire_Count=1, no refire.
REQ-037 Second rising edge during COOLDOWN -> ignored, count stays 1; edge after IDLE -> count 2; 256 shots -> count wraps to 0.
REQ-038 i_Rst_L=0 on 2nd FIRE cycle -> o_Fire=0, o_Busy=0, count=0, pan/tilt=128 next cycle.
REQ-039 SERVO_WATCHDOG_EN, pan=138, inputs idle -> o_Homing high after 20 cycles, pan returns to 128 at one step per tick; i_Up pulse clears o_Homing.

Source files
------------

// File: rtl/servo_cmd_scheduler.sv
// -----------------------------------------------------------------------------
// servo_cmd_scheduler
//
// Pan/tilt position stepper plus a trigger sequencer for a small servo turret.
//
// Position:
//   * A free-running step counter produces a one-cycle tick every STEP_TICKS
//     cycles. On each tick, the direction levels move pan/tilt by one count.
//   * Positions saturate at POS_MIN..POS_MAX.
//
// Trigger:
//   * A rising edge of i_Trigger starts a shot: FIRE for FIRE_TICKS cycles,
//     then COOLDOWN for COOLDOWN_TICKS cycles, then back to IDLE.
//   * Edges seen while busy are ignored.
//
// Optional feature (macro SERVO_WATCHDOG_EN):
//   * An idle counter saturates at WDOG_TICKS when there is no input activity.
//   * At saturation, o_Homing is raised and each tick walks pan/tilt toward
//     POS_CENTER.
//   * Without the macro, o_Homing is tied low and positions hold when idle.
//
// Ports:
//   i_Clk          system clock
//   i_Rst_L        synchronous active-low reset
//   i_Left/Right   pan direction command levels
//   i_Up/Down      tilt direction command levels
//   i_Trigger      fire request level
//   o_Pan/o_Tilt   commanded servo positions (8 bit)
//   o_Fire         trigger servo drive, high while in FIRE
//   o_Busy         high while the trigger sequencer is not idle
//   o_Fire_Count   shots fired, wrapping at 256
//   o_Homing       high while watchdog homing is active
// -----------------------------------------------------------------------------
module servo_cmd_scheduler #(
    parameter int unsigned STEP_TICKS     = 250000,
    parameter int unsigned POS_MIN        = 16,
    parameter int unsigned POS_MAX        = 240,
    parameter int unsigned POS_CENTER     = 128,
    parameter int unsigned FIRE_TICKS     = 12500000,
    parameter int unsigned COOLDOWN_TICKS = 25000000,
    parameter int unsigned WDOG_TICKS     = 250000000
) (
    input  logic       i_Clk,
    input  logic       i_Rst_L,
    input  logic       i_Left,
    input  logic       i_Right,
    input  logic       i_Up,
    input  logic       i_Down,
    input  logic       i_Trigger,
    output logic [7:0] o_Pan,
    output logic [7:0] o_Tilt,
    output logic       o_Fire,
    output logic       o_Busy,
    output logic [7:0] o_Fire_Count,
    output logic       o_Homing
);

    // Refuse to elaborate with parameters that would break the timers or bounds.
    if (STEP_TICKS == 0 || FIRE_TICKS == 0 || COOLDOWN_TICKS == 0 || WDOG_TICKS == 0 ||
        POS_MIN > POS_CENTER || POS_CENTER > POS_MAX || POS_MAX > 255) begin : g_bad_params
        $error("servo_cmd_scheduler: invalid parameter set");
    end

    localparam logic [7:0] PosMin    = 8'(POS_MIN);
    localparam logic [7:0] PosMax    = 8'(POS_MAX);
    localparam logic [7:0] PosCenter = 8'(POS_CENTER);

    // -------------------------------------------------------------------------
    // Step tick generator
    // -------------------------------------------------------------------------
    logic [31:0] step_cnt_q;
    logic        step_tick;

    assign step_tick = (step_cnt_q == STEP_TICKS - 1);

    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            step_cnt_q <= '0;
        end else if (step_tick) begin
            step_cnt_q <= '0;
        end else begin
            step_cnt_q <= step_cnt_q + 32'd1;
        end
    end

    // -------------------------------------------------------------------------
    // Idle watchdog (optional)
    // -------------------------------------------------------------------------
    logic homing;

`ifdef SERVO_WATCHDOG_EN
    logic [31:0] idle_cnt_q;
    logic [31:0] idle_cnt_d;
    logic        activity;

    assign activity = i_Left | i_Right | i_Up | i_Down | i_Trigger;

    always_comb begin
        idle_cnt_d = idle_cnt_q;
        if (activity) begin
            idle_cnt_d = '0;
        end else if (idle_cnt_q != WDOG_TICKS) begin
            idle_cnt_d = idle_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            idle_cnt_q <= '0;
        end else begin
            idle_cnt_q <= idle_cnt_d;
        end
    end

    assign homing = (idle_cnt_q == WDOG_TICKS);
`else
    assign homing = 1'b0;
`endif

    assign o_Homing = homing;

    // -------------------------------------------------------------------------
    // Pan / tilt position registers
    // -------------------------------------------------------------------------
    logic [7:0] pan_q;
    logic [7:0] pan_d;
    logic [7:0] tilt_q;
    logic [7:0] tilt_d;

    always_comb begin
        pan_d  = pan_q;
        tilt_d = tilt_q;
        if (step_tick) begin
            // Pan: an explicit single direction wins; otherwise home if idle long enough.
            if (i_Left && !i_Right) begin
                if (pan_q > PosMin) pan_d = pan_q - 8'd1;
            end else if (i_Right && !i_Left) begin
                if (pan_q < PosMax) pan_d = pan_q + 8'd1;
            end else if (homing) begin
                if (pan_q > PosCenter) begin
                    pan_d = pan_q - 8'd1;
                end else if (pan_q < PosCenter) begin
                    pan_d = pan_q + 8'd1;
                end
            end

            if (i_Up && !i_Down) begin
                if (tilt_q < PosMax) tilt_d = tilt_q + 8'd1;
            end else if (i_Down && !i_Up) begin
                if (tilt_q > PosMin) tilt_d = tilt_q - 8'd1;
            end else if (homing) begin
                if (tilt_q > PosCenter) begin
                    tilt_d = tilt_q - 8'd1;
                end else if (tilt_q < PosCenter) begin
                    tilt_d = tilt_q + 8'd1;
                end
            end
        end
    end

    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            pan_q  <= PosCenter;
            tilt_q <= PosCenter;
        end else begin
            pan_q  <= pan_d;
            tilt_q <= tilt_d;
        end
    end

    assign o_Pan  = pan_q;
    assign o_Tilt = tilt_q;

    // -------------------------------------------------------------------------
    // Trigger sequencer
    // -------------------------------------------------------------------------
    typedef enum logic [1:0] {
        StIdle,
        StFire,
        StCooldown
    } trig_state_e;

    trig_state_e state_q;
    trig_state_e state_d;
    logic [31:0] phase_cnt_q;
    logic [31:0] phase_cnt_d;
    logic [7:0]  fire_count_q;
    logic [7:0]  fire_count_d;
    logic        trig_q;
    logic        trig_rise;

    assign trig_rise = i_Trigger & ~trig_q;

    // State register (also holds the phase timer, shot counter and edge register)
    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            state_q      <= StIdle;
            phase_cnt_q  <= '0;
            fire_count_q <= '0;
            trig_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            phase_cnt_q  <= phase_cnt_d;
            fire_count_q <= fire_count_d;
            trig_q       <= i_Trigger;
        end
    end

    // Next-state logic
    always_comb begin
        state_d      = state_q;
        phase_cnt_d  = phase_cnt_q;
        fire_count_d = fire_count_q;
        unique case (state_q)
            StIdle: begin
                if (trig_rise) begin
                    state_d      = StFire;
                    phase_cnt_d  = '0;
                    fire_count_d = fire_count_q + 8'd1;
                end
            end
            StFire: begin
                if (phase_cnt_q == FIRE_TICKS - 1) begin
                    state_d     = StCooldown;
                    phase_cnt_d = '0;
                end else begin
                    phase_cnt_d = phase_cnt_q + 32'd1;
                end
            end
            StCooldown: begin
                if (phase_cnt_q == COOLDOWN_TICKS - 1) begin
                    state_d     = StIdle;
                    phase_cnt_d = '0;
                end else begin
                    phase_cnt_d = phase_cnt_q + 32'd1;
                end
            end
            default: begin
                state_d     = StIdle;
                phase_cnt_d = '0;
            end
        endcase
    end

    // Outputs decoded from the registered state
    always_comb begin
        o_Fire       = (state_q == StFire);
        o_Busy       = (state_q != StIdle);
        o_Fire_Count = fire_count_q;
    end

endmodule

// File: tb/tb_servo_cmd_scheduler.sv
// -----------------------------------------------------------------------------
// tb_servo_cmd_scheduler
//
// Directed bench for servo_cmd_scheduler with small timing parameters
// (STEP_TICKS=4, FIRE_TICKS=3, COOLDOWN_TICKS=5, WDOG_TICKS=20).
// Inputs are driven and outputs sampled 1 time unit after the rising edge.
// Watchdog checks follow SERVO_WATCHDOG_EN.
// -----------------------------------------------------------------------------
module tb_servo_cmd_scheduler;

    logic       clk;
    logic       rst_l;
    logic       left;
    logic       right;
    logic       up;
    logic       down;
    logic       trigger;
    logic [7:0] pan;
    logic [7:0] tilt;
    logic       fire;
    logic       busy;
    logic [7:0] fire_count;
    logic       homing;

    int tests_run    = 0;
    int tests_failed = 0;

    servo_cmd_scheduler #(
        .STEP_TICKS    (4),
        .POS_MIN       (16),
        .POS_MAX       (240),
        .POS_CENTER    (128),
        .FIRE_TICKS    (3),
        .COOLDOWN_TICKS(5),
        .WDOG_TICKS    (20)
    ) dut (
        .i_Clk       (clk),
        .i_Rst_L     (rst_l),
        .i_Left      (left),
        .i_Right     (right),
        .i_Up        (up),
        .i_Down      (down),
        .i_Trigger   (trigger),
        .o_Pan       (pan),
        .o_Tilt      (tilt),
        .o_Fire      (fire),
        .o_Busy      (busy),
        .o_Fire_Count(fire_count),
        .o_Homing    (homing)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin : main
        int fire_cycles;
        int busy_cycles;
        logic [7:0] pan_exp;

        rst_l   = 1'b0;
        left    = 1'b0;
        right   = 1'b0;
        up      = 1'b0;
        down    = 1'b0;
        trigger = 1'b0;
        step(2);

        // Reset state
        check("rst_pan", 32'(pan), 32'd128);
        check("rst_tilt", 32'(tilt), 32'd128);
        check("rst_fire", 32'(fire), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_count", 32'(fire_count), 32'd0);
        check("rst_homing", 32'(homing), 32'd0);

        // Pan right: one step every 4 cycles, first step 4 cycles after release
        rst_l = 1'b1;
        right = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            step(4);
            check("right_pan", 32'(pan), 32'(128 + k));
        end
        check("right_tilt", 32'(tilt), 32'd128);
        right = 1'b0;

`ifdef SERVO_WATCHDOG_EN
        // Idle: homing after 20 cycles, pan walks back to centre
        step(19);
        check("wdog_not_yet", 32'(homing), 32'd0);
        step(1);
        check("wdog_homing", 32'(homing), 32'd1);
        step(44);
        check("wdog_pan_home", 32'(pan), 32'd128);
        check("wdog_still_homing", 32'(homing), 32'd1);
        up = 1'b1;
        step(1);
        up = 1'b0;
        check("wdog_cleared", 32'(homing), 32'd0);
        pan_exp = 8'd128;
`else
        // No watchdog: positions hold and homing stays low while idle
        step(30);
        check("idle_homing", 32'(homing), 32'd0);
        check("idle_pan_hold", 32'(pan), 32'd138);
        pan_exp = 8'd138;
`endif

        // Tilt down to the lower bound; both pan directions cancel
        down  = 1'b1;
        left  = 1'b1;
        right = 1'b1;
        step(600);
        check("down_tilt_min", 32'(tilt), 32'd16);
        check("lr_pan_hold", 32'(pan), 32'(pan_exp));
        down  = 1'b0;
        left  = 1'b0;

        // Upper bound on both axes
        up = 1'b1;
        step(1000);
        check("up_tilt_max", 32'(tilt), 32'd240);
        check("right_pan_max", 32'(pan), 32'd240);
        up    = 1'b0;
        right = 1'b0;
        step(2);

        // Single shot with trigger held for 20 cycles
        trigger     = 1'b1;
        fire_cycles = 0;
        busy_cycles = 0;
        for (int i = 0; i < 20; i++) begin
            step(1);
            if (i == 0) check("fire_latency", 32'(fire), 32'd1);
            if (fire) fire_cycles++;
            if (busy) busy_cycles++;
        end
        check("fire_cycles", 32'(fire_cycles), 32'd3);
        check("busy_cycles", 32'(busy_cycles), 32'd8);
        check("count_one", 32'(fire_count), 32'd1);
        trigger = 1'b0;
        step(2);

        // Second shot, then an edge during cooldown which must be ignored
        trigger = 1'b1;
        step(1);
        check("shot2_fire", 32'(fire), 32'd1);
        check("shot2_count", 32'(fire_count), 32'd2);
        trigger = 1'b0;
        step(4);
        trigger = 1'b1;
        step(1);
        check("cooldown_fire", 32'(fire), 32'd0);
        check("cooldown_busy", 32'(busy), 32'd1);
        trigger = 1'b0;
        step(6);
        check("cooldown_idle", 32'(busy), 32'd0);
        check("cooldown_ignored", 32'(fire_count), 32'd2);
        trigger = 1'b1;
        step(1);
        check("shot3_count", 32'(fire_count), 32'd3);
        trigger = 1'b0;
        step(10);

        // Wrap the shot counter: 3 + 253 = 256 -> 0
        for (int s = 0; s < 253; s++) begin
            trigger = 1'b1;
            step(1);
            trigger = 1'b0;
            step(9);
        end
        check("count_wrap", 32'(fire_count), 32'd0);
        for (int s = 0; s < 3; s++) begin
            trigger = 1'b1;
            step(1);
            trigger = 1'b0;
            step(9);
        end
        check("count_after_wrap", 32'(fire_count), 32'd3);

        // Reset on the second FIRE cycle aborts the shot
        trigger = 1'b1;
        step(1);
        check("pre_rst_count", 32'(fire_count), 32'd4);
        step(1);
        check("pre_rst_fire", 32'(fire), 32'd1);
        rst_l   = 1'b0;
        trigger = 1'b0;
        step(1);
        check("abort_fire", 32'(fire), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_count", 32'(fire_count), 32'd0);
        check("abort_pan", 32'(pan), 32'd128);
        check("abort_tilt", 32'(tilt), 32'd128);

        // Step counter restarts from 0 after release
        rst_l = 1'b1;
        right = 1'b1;
        step(3);
        check("restart_no_step", 32'(pan), 32'd128);
        step(1);
        check("restart_first_step", 32'(pan), 32'd129);
        right = 1'b0;
        step(2);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
